// File: rtl/prism_aux_engine.sv
// prism_aux_engine: NUM_CNT countdown channels with optional auto-reload,
// a length-programmable serial shift register and a sticky status/mask
// interrupt unit on the TinyQV register bus.
// Optional build macro: PRISM_AUX_CAPTURE_EN adds per-channel count capture
// registers (input i_cnt_capture, reads at 0x20+4i).
module prism_aux_engine #(
  parameter int unsigned NUM_CNT     = 2,
  parameter int unsigned CNT_WIDTH   = 24,
  parameter int unsigned SHIFT_WIDTH = 32,
  parameter int unsigned SER_INPUTS  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_exec,
  input  logic [NUM_CNT-1:0]     i_cnt_load,
  input  logic [NUM_CNT-1:0]     i_cnt_dec,
`ifdef PRISM_AUX_CAPTURE_EN
  input  logic [NUM_CNT-1:0]     i_cnt_capture,
`endif
  input  logic                   i_shift_en,
  input  logic [SER_INPUTS-1:0]  i_ser_in,
  input  logic [5:0]             i_address,
  input  logic [31:0]            i_data_in,
  input  logic [1:0]             i_data_write_n,
  output logic [31:0]            o_data_out,
  output logic                   o_ser_out,
  output logic [NUM_CNT-1:0]     o_cnt_zero,
  output logic                   o_shift_cnt_zero,
  output logic                   o_irq
);

  localparam int unsigned SEL_W = (SER_INPUTS > 2) ? 2 : 1;
  localparam int unsigned IDX_W = $clog2(SHIFT_WIDTH);
  // Implemented STATUS / IRQ_MASK bits: one event per channel plus shift_done.
  localparam logic [16:0] STAT_MASK = {1'b1, 16'((32'd1 << NUM_CNT) - 32'd1)};

  logic [SEL_W-1:0]       r_ser_sel;
  logic                   r_dir;
  logic [4:0]             r_len_m1;
  logic [NUM_CNT-1:0]     r_autoreload;
  logic [16:0]            r_status;
  logic [16:0]            r_mask;
  logic [SHIFT_WIDTH-1:0] r_data;
  logic [5:0]             r_bit_cnt;
  logic [CNT_WIDTH-1:0]   r_preload [NUM_CNT];
  logic [CNT_WIDTH-1:0]   r_count   [NUM_CNT];
`ifdef PRISM_AUX_CAPTURE_EN
  logic [CNT_WIDTH-1:0]   r_capture [NUM_CNT];
`endif

  logic                   w_wr;
  logic [3:0]             w_widx;
  logic                   w_wr_shift;
  logic [16:0]            w_w1c;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt [NUM_CNT];
  logic [NUM_CNT-1:0]     w_evt;
  logic [5:0]             w_len_raw;
  logic [5:0]             w_len;
  logic [IDX_W-1:0]       w_top;
  logic [SHIFT_WIDTH-1:0] w_keep;
  logic [SHIFT_WIDTH-1:0] w_left;
  logic [SHIFT_WIDTH-1:0] w_right;
  logic [SHIFT_WIDTH-1:0] w_shifted;
  logic                   w_bit;
  logic                   w_shift;
  logic                   w_done_set;
  logic [16:0]            w_set;

  // Bus decode: only aligned 32-bit writes are accepted.
  assign w_widx     = i_address[5:2];
  assign w_wr       = (i_data_write_n == 2'b10) && (i_address[1:0] == 2'b00);
  assign w_wr_shift = w_wr && (w_widx == 4'd3);
  assign w_w1c      = (w_wr && (w_widx == 4'd1)) ? i_data_in[16:0] : 17'd0;

  // Countdown next-state and terminal-count events per channel.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      w_cnt_nxt[i] = r_count[i];
      w_evt[i]     = 1'b0;
      if (i_exec && i_cnt_load[i] && !i_cnt_dec[i]) begin
        w_cnt_nxt[i] = r_preload[i];
      end else if (i_exec && i_cnt_dec[i] && !i_cnt_load[i]) begin
        if (r_count[i] > CNT_WIDTH'(1)) begin
          w_cnt_nxt[i] = r_count[i] - CNT_WIDTH'(1);
        end else if (r_count[i] == CNT_WIDTH'(1)) begin
          w_cnt_nxt[i] = '0;
          w_evt[i]     = 1'b1;
        end else if (r_autoreload[i]) begin
          w_cnt_nxt[i] = r_preload[i];
        end
      end
    end
  end

  // Shift datapath: effective length, both directions, bits above length zeroed.
  always_comb begin
    w_len_raw = 6'(r_len_m1) + 6'd1;
    w_len     = (w_len_raw > 6'(SHIFT_WIDTH)) ? 6'(SHIFT_WIDTH) : w_len_raw;
    w_top     = IDX_W'(w_len - 6'd1);
    w_keep    = ~({SHIFT_WIDTH{1'b1}} << w_len);
    w_bit     = i_ser_in[r_ser_sel];
    w_left    = {r_data[SHIFT_WIDTH-2:0], w_bit};
    w_right   = {1'b0, r_data[SHIFT_WIDTH-1:1]};
    w_right[w_top] = w_bit;
    w_shifted = (r_dir ? w_right : w_left) & w_keep;
  end

  // A SHIFT_DATA write pre-empts a same-cycle shift.
  assign w_shift    = i_exec && i_shift_en && !w_wr_shift;
  assign w_done_set = w_shift && (r_bit_cnt == (w_len - 6'd1));
  assign w_set      = {w_done_set, 16'(w_evt)};

  // Control, status, mask and shift state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ser_sel    <= '0;
      r_dir        <= 1'b0;
      r_len_m1     <= '0;
      r_autoreload <= '0;
      r_status     <= '0;
      r_mask       <= '0;
      r_data       <= '0;
      r_bit_cnt    <= '0;
    end else begin
      if (w_wr && (w_widx == 4'd0)) begin
        r_ser_sel    <= i_data_in[SEL_W-1:0];
        r_dir        <= i_data_in[2];
        r_len_m1     <= i_data_in[7:3];
        r_autoreload <= i_data_in[8 +: NUM_CNT];
      end
      if (w_wr && (w_widx == 4'd2)) r_mask <= i_data_in[16:0] & STAT_MASK;
      r_status <= ((r_status & ~w_w1c) | w_set) & STAT_MASK;
      if (w_wr_shift) begin
        r_data    <= SHIFT_WIDTH'(i_data_in);
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_data    <= w_shifted;
        r_bit_cnt <= w_done_set ? 6'd0 : r_bit_cnt + 6'd1;
      end
    end
  end

  // Per-channel preload, live count and optional capture.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_CNT; i++) begin
      if (i_rst) begin
        r_preload[i] <= '0;
        r_count[i]   <= '0;
`ifdef PRISM_AUX_CAPTURE_EN
        r_capture[i] <= '0;
`endif
      end else begin
        if (w_wr && (w_widx == 4'(4 + i))) r_preload[i] <= CNT_WIDTH'(i_data_in);
        r_count[i] <= w_cnt_nxt[i];
`ifdef PRISM_AUX_CAPTURE_EN
        if (i_exec && i_cnt_capture[i]) r_capture[i] <= r_count[i];
`endif
      end
    end
  end

  // Combinational read mux; unmapped or unaligned addresses read 0.
  always_comb begin
    o_data_out = '0;
    if (i_address[1:0] == 2'b00) begin
      case (w_widx)
        4'd0:    o_data_out = 32'({r_autoreload, r_len_m1, r_dir, 2'(r_ser_sel)});
        4'd1:    o_data_out = 32'(r_status);
        4'd2:    o_data_out = 32'(r_mask);
        4'd3:    o_data_out = 32'(r_data);
        default: o_data_out = '0;
      endcase
      for (int i = 0; i < NUM_CNT; i++) begin
        if (w_widx == 4'(4 + i)) o_data_out = 32'(r_count[i]);
`ifdef PRISM_AUX_CAPTURE_EN
        if (w_widx == 4'(8 + i)) o_data_out = 32'(r_capture[i]);
`endif
      end
    end
  end

  // Level flags derived from registered state.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) o_cnt_zero[i] = (r_count[i] == '0);
  end

  assign o_ser_out        = r_dir ? r_data[0] : r_data[w_top];
  assign o_shift_cnt_zero = (r_bit_cnt == 6'd0);
  assign o_irq            = |(r_status & r_mask);

endmodule

// File: tb/tb_prism_aux_engine.sv
// Scoreboard bench for prism_aux_engine: the driver pushes expected values,
// a negedge monitor pops and compares against the selected DUT output.
module tb_prism_aux_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        exec;
  logic [1:0]  cnt_load;
  logic [1:0]  cnt_dec;
  logic [1:0]  cnt_capture;
  logic        shift_en;
  logic [3:0]  ser_in;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [31:0] data_out;
  logic        ser_out;
  logic [1:0]  cnt_zero;
  logic        shift_cnt_zero;
  logic        irq;

  localparam int S_DATA = 0, S_CZ = 1, S_IRQ = 2, S_SER = 3, S_SCZ = 4;

  typedef struct {
    string       nm;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  logic chk_pend = 1'b0;
  int   n_tests  = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  prism_aux_engine dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_exec           (exec),
    .i_cnt_load       (cnt_load),
    .i_cnt_dec        (cnt_dec),
`ifdef PRISM_AUX_CAPTURE_EN
    .i_cnt_capture    (cnt_capture),
`endif
    .i_shift_en       (shift_en),
    .i_ser_in         (ser_in),
    .i_address        (address),
    .i_data_in        (data_in),
    .i_data_write_n   (data_write_n),
    .o_data_out       (data_out),
    .o_ser_out        (ser_out),
    .o_cnt_zero       (cnt_zero),
    .o_shift_cnt_zero (shift_cnt_zero),
    .o_irq            (irq)
  );

  function automatic logic [31:0] pick(int s);
    case (s)
      S_DATA:  return data_out;
      S_CZ:    return 32'(cnt_zero);
      S_IRQ:   return 32'(irq);
      S_SER:   return 32'(ser_out);
      default: return 32'(shift_cnt_zero);
    endcase
  endfunction

  // Monitor: compare whatever the driver presented this cycle.
  always @(negedge clk) begin
    if (chk_pend) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: monitor saw a check with no expected entry");
      end else begin
        exp_t e;
        logic [31:0] act;
        e   = sb.pop_front();
        act = pick(e.sel);
        if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.nm, act, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int s, logic [31:0] v, logic [5:0] a);
    address = a;
    sb.push_back('{nm, s, v});
    chk_pend = 1'b1;
    tick();
    chk_pend = 1'b0;
  endtask

  task automatic rd(string nm, logic [5:0] a, logic [31:0] v);
    chk(nm, S_DATA, v, a);
  endtask

  task automatic wr(logic [5:0] a, logic [31:0] d);
    address = a; data_in = d; data_write_n = 2'b10;
    tick();
    data_write_n = 2'b11;
  endtask

  task automatic load(int ch);
    cnt_load[ch] = 1'b1;
    tick();
    cnt_load = '0;
  endtask

  task automatic dec(int ch);
    cnt_dec[ch] = 1'b1;
    tick();
    cnt_dec = '0;
  endtask

  task automatic shift_n(logic [7:0] v, int n, int sel, bit lsb_first);
    for (int k = 0; k < n; k++) begin
      ser_in      = '0;
      ser_in[sel] = lsb_first ? v[k] : v[7-k];
      shift_en    = 1'b1;
      tick();
    end
    shift_en = 1'b0;
    ser_in   = '0;
  endtask

  initial begin
    rst = 1'b1; exec = 1'b1; cnt_load = '0; cnt_dec = '0; cnt_capture = '0;
    shift_en = 1'b0; ser_in = '0; address = '0; data_in = '0; data_write_n = 2'b11;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    rd("rst_ctrl", 6'h00, 32'h0);
    rd("rst_status", 6'h04, 32'h0);
    rd("rst_mask", 6'h08, 32'h0);
    rd("rst_shift", 6'h0C, 32'h0);
    rd("rst_cnt0", 6'h10, 32'h0);
    rd("rst_cnt1", 6'h14, 32'h0);
    chk("rst_cnt_zero", S_CZ, 32'h3, 6'h00);
    chk("rst_irq", S_IRQ, 32'h0, 6'h00);
    chk("rst_scz", S_SCZ, 32'h1, 6'h00);
    chk("rst_ser_out", S_SER, 32'h0, 6'h00);

    // Countdown 3 -> 0 with event and interrupt
    wr(6'h10, 32'd3);
    load(0);
    rd("cnt0_loaded", 6'h10, 32'd3);
    chk("cz_after_load", S_CZ, 32'h2, 6'h00);
    wr(6'h08, 32'h1);
    dec(0); rd("cnt0_dec1", 6'h10, 32'd2);
    dec(0); rd("cnt0_dec2", 6'h10, 32'd1);
    rd("status_before_evt", 6'h04, 32'h0);
    dec(0);
    rd("status_evt", 6'h04, 32'h1);
    rd("cnt0_dec3", 6'h10, 32'd0);
    chk("irq_set", S_IRQ, 32'h1, 6'h00);
    chk("cz_at_zero", S_CZ, 32'h3, 6'h00);
    wr(6'h04, 32'h1);
    chk("irq_cleared", S_IRQ, 32'h0, 6'h00);
    rd("status_cleared", 6'h04, 32'h0);
    dec(0);
    rd("cnt0_hold_zero", 6'h10, 32'd0);
    rd("no_evt_at_zero", 6'h04, 32'h0);

    // Auto-reload, period preload+1
    wr(6'h00, 32'h100);
    wr(6'h10, 32'd2);
    load(0);
    dec(0); rd("ar_dec1", 6'h10, 32'd1);
    dec(0); rd("ar_dec2", 6'h10, 32'd0);
    rd("ar_evt1", 6'h04, 32'h1);
    wr(6'h04, 32'h1);
    dec(0); rd("ar_dec3", 6'h10, 32'd2);
    rd("ar_reload_no_evt", 6'h04, 32'h0);
    dec(0); rd("ar_dec4", 6'h10, 32'd1);
    dec(0); rd("ar_dec5", 6'h10, 32'd0);
    rd("ar_evt2", 6'h04, 32'h1);
    dec(0); rd("ar_dec6", 6'h10, 32'd2);
    exec = 1'b0;
    dec(0);
    exec = 1'b1;
    rd("exec0_hold", 6'h10, 32'd2);
    wr(6'h04, 32'h1);

    // Load+dec together holds; event beats same-cycle W1C
    cnt_load[0] = 1'b1; cnt_dec[0] = 1'b1;
    tick();
    cnt_load = '0; cnt_dec = '0;
    rd("load_dec_hold", 6'h10, 32'd2);
    dec(0);
    address = 6'h04; data_in = 32'h1; data_write_n = 2'b10; cnt_dec[0] = 1'b1;
    tick();
    data_write_n = 2'b11; cnt_dec = '0;
    rd("set_beats_w1c", 6'h04, 32'h1);
    wr(6'h04, 32'h1FFFF);

    // MSB-first left shift of 0xA5, length 8
    wr(6'h00, 32'h38);
    wr(6'h0C, 32'h0);
    shift_n(8'hA5, 4, 0, 1'b0);
    rd("msb_half", 6'h0C, 32'h0000000A);
    chk("msb_half_scz", S_SCZ, 32'h0, 6'h00);
    shift_n(8'hA5 << 4, 4, 0, 1'b0);
    rd("msb_data", 6'h0C, 32'h000000A5);
    rd("msb_done", 6'h04, 32'h10000);
    chk("msb_scz", S_SCZ, 32'h1, 6'h00);
    chk("msb_ser_out", S_SER, 32'h1, 6'h00);
    chk("done_masked_irq", S_IRQ, 32'h0, 6'h00);
    wr(6'h04, 32'h1FFFF);

    // LSB-first right shift of 0xA5 on serial pin 2
    wr(6'h00, 32'h3E);
    wr(6'h0C, 32'h0);
    shift_n(8'hA5, 4, 2, 1'b1);
    rd("lsb_half", 6'h0C, 32'h00000050);
    shift_n(8'hA5 >> 4, 4, 2, 1'b1);
    rd("lsb_data", 6'h0C, 32'h000000A5);
    rd("lsb_done", 6'h04, 32'h10000);
    chk("lsb_ser_out", S_SER, 32'h1, 6'h00);
    wr(6'h04, 32'h1FFFF);

    // SHIFT_DATA write wins over a same-cycle shift
    shift_n(8'hFF, 3, 2, 1'b1);
    chk("pre_write_scz", S_SCZ, 32'h0, 6'h00);
    address = 6'h0C; data_in = 32'h12345678; data_write_n = 2'b10;
    shift_en = 1'b1; ser_in = 4'hF;
    tick();
    data_write_n = 2'b11; shift_en = 1'b0; ser_in = '0;
    rd("wr_beats_shift", 6'h0C, 32'h12345678);
    chk("wr_clears_cnt", S_SCZ, 32'h1, 6'h00);
    rd("wr_no_done", 6'h04, 32'h0);

    // Mid-shift reset, then a full 8-bit frame from counter 0
    load(0); dec(0); dec(0);
    wr(6'h00, 32'h38);
    wr(6'h0C, 32'h0);
    shift_n(8'hFF, 3, 0, 1'b0);
    rd("pre_rst_data", 6'h0C, 32'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd("post_rst_data", 6'h0C, 32'h0);
    rd("post_rst_status", 6'h04, 32'h0);
    rd("post_rst_cnt0", 6'h10, 32'h0);
    rd("post_rst_ctrl", 6'h00, 32'h0);
    chk("post_rst_scz", S_SCZ, 32'h1, 6'h00);
    chk("post_rst_cz", S_CZ, 32'h3, 6'h00);
    wr(6'h00, 32'h38);
    shift_n(8'hFF, 7, 0, 1'b0);
    rd("frame_7_no_done", 6'h04, 32'h0);
    shift_n(8'hFF, 1, 0, 1'b0);
    rd("frame_8_done", 6'h04, 32'h10000);
    rd("frame_data", 6'h0C, 32'hFF);

    // Register map boundaries
    wr(6'h00, 32'hFFFFFFFF);
    rd("ctrl_readback", 6'h00, 32'h3FF);
    address = 6'h08; data_in = 32'h1; data_write_n = 2'b01;
    tick();
    data_write_n = 2'b11;
    rd("narrow_write_ignored", 6'h08, 32'h0);
    wr(6'h14, 32'd5);
    load(1);
    rd("cnt1_loaded", 6'h14, 32'd5);
    chk("cz_ch1_only", S_CZ, 32'h1, 6'h00);
    rd("unmapped_3c", 6'h3C, 32'h0);
    rd("unmapped_18", 6'h18, 32'h0);

    tick(); tick();
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
